// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor scan/average block.
// Holds the controller state encoding and parameter-legality limits.
package sensor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  localparam int MIN_NUM_CH       = 2;
  localparam int MAX_NUM_CH       = 16;
  // A scan must fit inside one period with at least one WAIT cycle left over.
  localparam int MIN_PERIOD_SLACK = 1;

  function automatic int min_period(input int num_ch);
    return num_ch + MIN_PERIOD_SLACK;
  endfunction

endpackage

// File: rtl/sensor_period_timer.sv
// Free-running scan period counter.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   run  : count while high; held at 0 while low
//   tick : high in the last cycle of each period (count == PERIOD-1)
module sensor_period_timer #(
  parameter int PERIOD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Gated by run so a stop request in the wrap cycle cannot also fire a tick.
  assign tick = run && (cnt_q == CNT_W'(PERIOD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!run)      cnt_d = '0;
    else if (tick) cnt_d = '0;
    else           cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sensor_array.sv
// Periodic multi-channel sensor scanner with averaging and threshold alerts.
// Every PERIOD cycles one scan samples all channels (one per cycle); after
// 2^AVG_LOG2 scans the per-channel averages are streamed out over a
// valid/ready port and the alert flags are refreshed.
//   clk, rst            : clock, synchronous active-high reset
//   enable              : run/stop; low forces IDLE and drops pending output
//   environment         : packed raw channel values, channel k at [k*DATA_W +: DATA_W]
//   threshold           : unsigned alert threshold (strict greater-than)
//   data/data_ch        : averaged value and its channel index
//   data_valid/ready    : output handshake
//   alert               : per-channel avg > threshold from the last average
//   overrun             : sticky, a period tick arrived while still draining
module sensor_array
  import sensor_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int PERIOD   = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_CH*DATA_W-1:0]  environment,
  input  logic [DATA_W-1:0]         threshold,
  output logic [DATA_W-1:0]         data,
  output logic [$clog2(NUM_CH)-1:0] data_ch,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic [NUM_CH-1:0]         alert,
  output logic                      overrun
);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int SCAN_W = AVG_LOG2 + 1;
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [SCAN_W-1:0] NUM_SCANS = SCAN_W'(1 << AVG_LOG2);

  state_e                        state_q, state_d;
  logic [CH_W-1:0]               idx_q, idx_d, idx_nxt;
  logic [SCAN_W-1:0]             scan_q, scan_d, scan_inc;
  logic [NUM_CH-1:0][ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [NUM_CH-1:0][DATA_W-1:0] avg_q, avg_d;
  logic [DATA_W-1:0]             data_q, data_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic [NUM_CH-1:0]             alert_q, alert_d;
  logic                          ovr_q, ovr_d;
  logic                          run, tick;

  // Counter runs only while the controller is active and will stay active,
  // so a stop clears it on the same edge that enters IDLE.
  assign run = (state_q != IDLE) && enable;

  sensor_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  assign idx_nxt  = idx_q + CH_W'(1);
  assign scan_inc = scan_q + SCAN_W'(1);

  // Accumulators including this cycle's sample, so the final SAMPLE cycle
  // can compute averages for the last channel without an extra stage.
  always_comb begin
    acc_sum = acc_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (state_q == SAMPLE && idx_q == CH_W'(k))
        acc_sum[k] = acc_q[k] + ACC_W'(environment[k*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    scan_d  = scan_q;
    acc_d   = acc_q;
    avg_d   = avg_q;
    data_d  = data_q;
    ch_d    = ch_q;
    alert_d = alert_q;
    ovr_d   = ovr_q;

    if (state_q != IDLE && !enable) begin
      // Abort: output registers and flags are kept, work in flight is lost.
      state_d = IDLE;
      idx_d   = '0;
      scan_d  = '0;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        IDLE:   if (enable) state_d = WAIT;
        WAIT:   if (tick) state_d = SAMPLE;
        SAMPLE: begin
          acc_d = acc_sum;
          if (idx_q == LAST_CH) begin
            idx_d = '0;
            if (scan_inc == NUM_SCANS) begin
              state_d = DRAIN;
              scan_d  = '0;
              acc_d   = '0;
              for (int k = 0; k < NUM_CH; k++) begin
                // Dropping the low AVG_LOG2 bits is the floor divide.
                avg_d[k]   = acc_sum[k][AVG_LOG2 +: DATA_W];
                alert_d[k] = acc_sum[k][AVG_LOG2 +: DATA_W] > threshold;
              end
              data_d = acc_sum[0][AVG_LOG2 +: DATA_W];
              ch_d   = '0;
            end else begin
              state_d = WAIT;
              scan_d  = scan_inc;
            end
          end else begin
            idx_d = idx_nxt;
          end
        end
        DRAIN: begin
          // The scan due at this tick is simply not started.
          if (tick) ovr_d = 1'b1;
          if (data_ready) begin
            if (idx_q == LAST_CH) begin
              state_d = WAIT;
              idx_d   = '0;
            end else begin
              idx_d  = idx_nxt;
              data_d = avg_q[idx_nxt];
              ch_d   = idx_nxt;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      scan_q  <= '0;
      acc_q   <= '0;
      avg_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      alert_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      scan_q  <= scan_d;
      acc_q   <= acc_d;
      avg_q   <= avg_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      alert_q <= alert_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data       = data_q;
  assign data_ch    = ch_q;
  assign data_valid = (state_q == DRAIN);
  assign alert      = alert_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sensor_array.sv
// Randomized bench for sensor_array with a queue-based reference model.
module tb_sensor_array;
  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int PER   = 8;
  localparam int AL    = 2;
  localparam int NSCAN = 1 << AL;

  typedef struct { int ch; int val; } beat_t;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [NCH*DW-1:0] environment;
  logic [DW-1:0]     threshold;
  logic [DW-1:0]     data;
  logic [1:0]        data_ch;
  logic              data_valid;
  logic              data_ready;
  logic [NCH-1:0]    alert;
  logic              overrun;

  sensor_array #(.NUM_CH(NCH), .DATA_W(DW), .PERIOD(PER), .AVG_LOG2(AL)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .environment (environment),
    .threshold   (threshold),
    .data        (data),
    .data_ch     (data_ch),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .alert       (alert),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a period position, an in-progress scan, per-channel
  // sums and a queue of averaged beats waiting to be delivered.
  bit           m_run, m_samp, m_ovr;
  int           m_pos, m_k, m_scans, m_data, m_ch;
  int           m_sum[NCH];
  logic [NCH-1:0] m_alert;
  beat_t        m_pend[$];
  beat_t        obs[$];

  task automatic model_step();
    bit    tk;
    beat_t b;
    if (rst) begin
      m_run = 0; m_samp = 0; m_ovr = 0; m_pos = 0; m_k = 0; m_scans = 0;
      m_data = 0; m_ch = 0; m_alert = '0; m_pend.delete();
      foreach (m_sum[k]) m_sum[k] = 0;
    end else if (!m_run) begin
      if (enable) begin m_run = 1; m_pos = 0; end
    end else if (!enable) begin
      m_run = 0; m_samp = 0; m_pos = 0; m_scans = 0; m_pend.delete();
      foreach (m_sum[k]) m_sum[k] = 0;
    end else begin
      tk = (m_pos == PER - 1);
      if (m_samp) begin
        m_sum[m_k] += int'(environment[m_k*DW +: DW]);
        if (m_k == NCH - 1) begin
          m_samp = 0;
          m_scans++;
          if (m_scans == NSCAN) begin
            for (int k = 0; k < NCH; k++) begin
              b.ch = k; b.val = m_sum[k] / NSCAN;
              m_pend.push_back(b);
              m_alert[k] = (b.val > int'(threshold));
              m_sum[k] = 0;
            end
            m_scans = 0;
            m_data = m_pend[0].val; m_ch = m_pend[0].ch;
          end
        end else m_k++;
      end else if (m_pend.size() > 0) begin
        if (tk) m_ovr = 1;
        if (data_ready) begin
          void'(m_pend.pop_front());
          if (m_pend.size() > 0) begin m_data = m_pend[0].val; m_ch = m_pend[0].ch; end
        end
      end else if (tk) begin
        m_samp = 1; m_k = 0;
      end
      m_pos = tk ? 0 : m_pos + 1;
    end
  endtask

  // One clock: log DUT transfers, advance model, compare after the edge.
  task automatic cyc();
    beat_t b;
    if (data_valid && data_ready && enable && !rst) begin
      b.ch = int'(data_ch); b.val = int'(data); obs.push_back(b);
    end
    model_step();
    @(posedge clk); #1;
    chk("data_valid", data_valid, (m_pend.size() > 0) ? 1 : 0);
    chk("data", data, m_data);
    chk("data_ch", data_ch, m_ch);
    chk("alert", alert, m_alert);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic wait_beats(input int n, input int bound);
    for (int i = 0; i < bound && obs.size() < n; i++) cyc();
    if (obs.size() < n) chk("beat_timeout", obs.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0; obs.delete();
  endtask

  logic [7:0] exp_v[NCH];
  logic [7:0] cv[NCH];
  int lat;

  initial begin
    rst = 1'b1; enable = 1'b1; data_ready = 1'b0; threshold = 8'h00;
    environment = 32'hA5C3_7E19;

    // Reset dominates enable with nonzero inputs.
    repeat (2) begin
      cyc();
      chk("rst_valid", data_valid, 0);
      chk("rst_data", data, 0);
      chk("rst_alert", alert, 0);
      chk("rst_overrun", overrun, 0);
    end

    // Constant channels -> exact averages and strict-threshold alerts.
    rst = 1'b0; obs.delete();
    environment = 32'hFF50_0F00; threshold = 8'h50; data_ready = 1'b1;
    exp_v[0] = 8'h00; exp_v[1] = 8'h0F; exp_v[2] = 8'h50; exp_v[3] = 8'hFF;
    wait_beats(4, 200);
    for (int i = 0; i < NCH && i < obs.size(); i++) begin
      chk("const_ch", obs[i].ch, i);
      chk("const_val", obs[i].val, exp_v[i]);
    end
    chk("const_alert", alert, 4'b1000);

    // Truncation on ch0: samples 1,2,2,2 average to 1.
    do_reset();
    environment = 32'h3344_5500;
    for (int i = 0; i < 200 && obs.size() < 4; i++) begin
      environment[7:0] = (m_scans == 0) ? 8'h01 : 8'h02;
      cyc();
    end
    if (obs.size() > 0) chk("trunc_ch0", obs[0].val, 8'h01);
    else chk("trunc_timeout", obs.size(), 1);

    // Full-scale inputs do not overflow.
    environment = 32'hFFFF_FFFF; obs.delete();
    wait_beats(8, 300);
    for (int i = 4; i < 8 && i < obs.size(); i++) chk("fullscale", obs[i].val, 8'hFF);

    // Backpressure: stable hold, then overrun and a later complete average.
    do_reset();
    environment = $urandom();
    for (int k = 0; k < NCH; k++) cv[k] = environment[k*DW +: DW];
    data_ready = 1'b1;
    for (int i = 0; i < 100 && !data_valid; i++) cyc();
    chk("bp_valid_seen", data_valid, 1);
    data_ready = 1'b0;
    repeat (3) begin
      cyc();
      chk("stall_data", data, cv[0]);
      chk("stall_ch", data_ch, 0);
    end
    for (int i = 0; i < 20 && !overrun; i++) cyc();
    chk("overrun_set", overrun, 1);
    data_ready = 1'b1; obs.delete();
    wait_beats(8, 300);
    for (int i = 4; i < 8 && i < obs.size(); i++) begin
      chk("bp_ch", obs[i].ch, i - 4);
      chk("bp_val", obs[i].val, cv[i-4]);
    end

    // Stop during the third scan's sampling, then restart from scratch.
    do_reset();
    environment = $urandom();
    for (int i = 0; i < 100 && !(m_samp && m_scans == 2 && m_k == 1); i++) cyc();
    chk("scan3_reached", m_scans, 2);
    enable = 1'b0;
    repeat (5) begin cyc(); chk("stop_novalid", data_valid, 0); end
    enable = 1'b1;
    cyc();
    lat = 0;
    while (!data_valid && lat < 100) begin cyc(); lat++; end
    chk("reenable_latency", lat, NSCAN * PER + NCH);

    // Random traffic with occasional stops and resets.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      environment = $urandom();
      data_ready  = ($urandom_range(3) != 0);
      if ($urandom_range(99) == 0) threshold = 8'($urandom());
      if ($urandom_range(199) == 0) enable = ~enable;
      else if (!enable && $urandom_range(3) == 0) enable = 1'b1;
      rst = ($urandom_range(499) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_array.md
SENSOR_ARRAY -- requirements
Module: sensor_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of sensor channels (legal range 2..16).
REQ-002 SHALL have parameter DATA_W, default 8: width of each channel sample and of the output.
REQ-003 SHALL have parameter PERIOD, default 16: scan period in clk cycles (legal minimum NUM_CH+1).
REQ-004 SHALL have parameter AVG_LOG2, default 2: averaging uses 2^AVG_LOG2 scans (0 = no averaging).
REQ-005 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-007 SHALL have port enable  input  1  run/stop control.
REQ-008 SHALL have port environment  input  NUM_CH*DATA_W  channel k raw value in bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port threshold  input  DATA_W  unsigned alert threshold shared by all channels.
REQ-010 SHALL have port data  output  DATA_W  averaged sample being offered.
REQ-011 SHALL have port data_ch  output  $clog2(NUM_CH)  channel index of data.
REQ-012 SHALL have port data_valid  output  1  data/data_ch are valid.
REQ-013 SHALL have port data_ready  input  1  consumer accepts; transfer occurs when data_valid && data_ready.
REQ-014 SHALL have port alert  output  NUM_CH  per-channel threshold-exceeded flag.
REQ-015 SHALL have port overrun  output  1  sticky flag: a scan was dropped.

Function
REQ-016 SHALL implement states IDLE, WAIT, SAMPLE, DRAIN.
REQ-017 IDLE: on an edge with enable=1, go to WAIT with the period counter at 0.
REQ-018 The period counter SHALL count 0..PERIOD-1 and wrap whenever state != IDLE; tick = (count == PERIOD-1).
REQ-019 WAIT: on tick, go to SAMPLE; the first tick occurs in the PERIOD-th WAIT cycle after leaving IDLE.
REQ-020 SAMPLE SHALL last exactly NUM_CH cycles; in cycle k (0-based), the channel k slice is added to accumulator k.
REQ-021 Accumulators SHALL be DATA_W+AVG_LOG2 bits, unsigned, and cannot overflow.
REQ-022 SAMPLE exit: increment the scan count; if the scan count now equals 2^AVG_LOG2, go to DRAIN, otherwise go to WAIT.
REQ-023 On the SAMPLE->DRAIN edge:
- avg[k] = floor(sum of the 2^AVG_LOG2 samples / 2^AVG_LOG2);
- accumulators and scan count clear;
- alert[k] updates to (avg[k] > threshold), strict compare.
REQ-024 Alert bits SHALL change only at REQ-023 and reset; they are retained through IDLE.
REQ-025 DRAIN:
- data_valid=1, data=avg[i], data_ch=i, with i starting at 0;
- each transfer advances i;
- the transfer of i=NUM_CH-1 returns to WAIT, with data_valid low the next cycle.
REQ-026 While data_valid=1 and data_ready=0, data and data_ch SHALL remain stable.
REQ-027 A tick in DRAIN SHALL set overrun (sticky until rst); that scan is skipped and draining continues.
REQ-028 data_valid SHALL first rise in the cycle after the last SAMPLE cycle (latency NUM_CH+1 cycles from tick).
REQ-029 enable=0 in any non-IDLE state SHALL, at the next edge:
- enter IDLE;
- clear the period counter, accumulators, scan count and drain index;
- drop pending output (data_valid=0);
- leave data, alert and overrun unchanged.
REQ-030 When NUM_CH < 2^$clog2(NUM_CH), unused data_ch codes SHALL never be driven.

Reset
REQ-031 rst SHALL take priority over enable and data_ready.
REQ-032 Reset values: state IDLE; data=0, data_ch=0, data_valid=0, alert=0, overrun=0; all counters and accumulators 0.
REQ-033 Reset asserted mid-SAMPLE or mid-DRAIN SHALL abandon the operation with no partial output.

Structure
REQ-034 Package sensor_pkg SHALL hold the state enum and parameter-legality constants (minimum PERIOD, maximum NUM_CH).
REQ-035 The period counter and tick SHALL be the sub-module sensor_period_timer (ports clk, rst, run, tick).

Verification (NUM_CH=4, DATA_W=8, PERIOD=8, AVG_LOG2=2)
REQ-036 rst=1 for 2 cycles with enable=1 and nonzero environment -> all outputs 0, no data_valid.
REQ-037 Constant channels 0x00/0x0F/0x50/0xFF, threshold=0x50, data_ready=1 -> four beats (ch0..3) of 0x00, 0x0F, 0x50, 0xFF; alert=4'b1000.
REQ-038 ch0 samples 0x01, 0x02, 0x02, 0x02 over 4 scans -> data=0x01 (truncation); all channels 0xFF -> 0xFF (no overflow).
REQ-039 data_ready=0 for 3 DRAIN cycles -> data/data_ch stable; hold data_ready=0 past the next tick -> overrun=1, and the next output follows 4 further completed scans.
REQ-040 enable dropped during SAMPLE of scan 3 -> no data_valid; after re-enable, the first beat appears only after 4 fresh scans.
